// File: rtl/menu_ctrl.sv
// -----------------------------------------------------------------------------
// menu_ctrl
//   Front-panel menu state machine for the display/game datapath. Converts
//   debounced button levels and the datapath's exit request into the menu
//   cursor, the display mux select and a reset pulse for both games.
//
//   States: MENU (cursor moves, confirm launches), LAUNCH (games held in reset
//   for RST_CYCLES cycles), PLAY (game running until exit is held for
//   EXIT_CYCLES consecutive cycles).
//
// Ports
//   sys_clk      in   1  system clock, rising edge
//   sys_rst      in   1  synchronous active-high reset
//   button_up    in   1  debounced level, moves cursor back (mod 2)
//   button_down  in   1  debounced level, moves cursor forward (mod 2)
//   button_left  in   1  debounced level, cancel/back: nothing to cancel
//   button_right in   1  debounced level, confirm in MENU
//   exit         in   1  exit request level from datapath
//   choice       out  2  menu cursor: 0 = snake, 1 = bar game
//   vga_mux      out  2  0 = menu background, 1 = snake, 2 = bar game
//   game_rst     out  1  active-high reset to both games
//   in_game      out  1  high only in PLAY
// -----------------------------------------------------------------------------
module menu_ctrl #(
    parameter int RST_CYCLES  = 16,
    parameter int EXIT_CYCLES = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       button_up,
    input  logic       button_down,
    input  logic       button_left,
    input  logic       button_right,
    input  logic       exit,
    output logic [1:0] choice,
    output logic [1:0] vga_mux,
    output logic       game_rst,
    output logic       in_game
);

    localparam int LW = $clog2(RST_CYCLES + 1);
    localparam int EW = $clog2(EXIT_CYCLES + 1);
    localparam logic [LW-1:0] LAUNCH_LAST = LW'(RST_CYCLES - 1);
    localparam logic [EW-1:0] EXIT_DONE   = EW'(EXIT_CYCLES);

    typedef enum logic [1:0] {
        MENU   = 2'd0,
        LAUNCH = 2'd1,
        PLAY   = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [1:0]     choice_nxt;
    logic [1:0]     vga_mux_nxt;
    logic           game_rst_nxt;
    logic           in_game_nxt;
    logic [LW-1:0]  launch_cnt, launch_cnt_nxt;
    logic [EW-1:0]  exit_cnt, exit_cnt_nxt;

    // Button order in the vectors below: {right, down, up}
    logic [2:0]     btn;
    logic [2:0]     hist;
    logic [2:0]     ev_p0;

    // Left is a cancel/back key; the menu has nothing to cancel, so it is
    // deliberately consumed without effect.
    logic           unused_left;
    assign unused_left = button_left;

    assign btn = {button_right, button_down, button_up};

    // Cursor arithmetic on a two-entry menu: both directions wrap.
    function automatic logic [1:0] cursor_prev(input logic [1:0] cur);
        return (cur == 2'd0) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [1:0] cursor_next(input logic [1:0] cur);
        return (cur == 2'd1) ? 2'd0 : 2'd1;
    endfunction

    function automatic logic [1:0] game_select(input logic [1:0] cur);
        return (cur == 2'd0) ? 2'd1 : 2'd2;
    endfunction

    // Stage p0: press events. History resets high so a button held through
    // reset (or across PLAY -> MENU) never looks like a fresh press.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            hist  <= 3'b111;
            ev_p0 <= 3'b000;
        end else begin
            hist  <= btn;
            ev_p0 <= btn & ~hist;
        end
    end

    // Stage p1: state and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= MENU;
            choice     <= 2'd0;
            vga_mux    <= 2'd0;
            game_rst   <= 1'b1;
            in_game    <= 1'b0;
            launch_cnt <= '0;
            exit_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            choice     <= choice_nxt;
            vga_mux    <= vga_mux_nxt;
            game_rst   <= game_rst_nxt;
            in_game    <= in_game_nxt;
            launch_cnt <= launch_cnt_nxt;
            exit_cnt   <= exit_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        choice_nxt     = choice;
        vga_mux_nxt    = vga_mux;
        game_rst_nxt   = game_rst;
        in_game_nxt    = in_game;
        launch_cnt_nxt = launch_cnt;
        exit_cnt_nxt   = exit_cnt;

        case (state)
            MENU: begin
                vga_mux_nxt  = 2'd0;
                game_rst_nxt = 1'b1;
                in_game_nxt  = 1'b0;
                exit_cnt_nxt = '0;
                // Confirm takes priority and freezes the cursor.
                if (ev_p0[2]) begin
                    state_nxt      = LAUNCH;
                    launch_cnt_nxt = '0;
                    vga_mux_nxt    = game_select(choice);
                end else if (ev_p0[0] && !ev_p0[1]) begin
                    choice_nxt = cursor_prev(choice);
                end else if (ev_p0[1] && !ev_p0[0]) begin
                    choice_nxt = cursor_next(choice);
                end
            end

            LAUNCH: begin
                game_rst_nxt = 1'b1;
                in_game_nxt  = 1'b0;
                if (exit) begin
                    state_nxt      = MENU;
                    vga_mux_nxt    = 2'd0;
                    launch_cnt_nxt = '0;
                end else if (launch_cnt == LAUNCH_LAST) begin
                    state_nxt      = PLAY;
                    game_rst_nxt   = 1'b0;
                    in_game_nxt    = 1'b1;
                    launch_cnt_nxt = '0;
                    exit_cnt_nxt   = '0;
                end else begin
                    launch_cnt_nxt = launch_cnt + 1'b1;
                end
            end

            PLAY: begin
                // Once the run of highs is complete, leave on the next edge
                // regardless of the exit level at that point.
                if (exit_cnt == EXIT_DONE) begin
                    state_nxt    = MENU;
                    vga_mux_nxt  = 2'd0;
                    game_rst_nxt = 1'b1;
                    in_game_nxt  = 1'b0;
                    exit_cnt_nxt = '0;
                end else if (exit) begin
                    exit_cnt_nxt = exit_cnt + 1'b1;
                end else begin
                    exit_cnt_nxt = '0;
                end
            end

            default: begin
                state_nxt    = MENU;
                vga_mux_nxt  = 2'd0;
                game_rst_nxt = 1'b1;
                in_game_nxt  = 1'b0;
            end
        endcase
    end

endmodule
